// File: rtl/icd_mem_master_pkg.sv
// Shared constants and types for the ICD memory-bus initiator.
package icd_mem_master_pkg;

  // SRAM byte-address width: MAH[20:12] plus MAL[11:0], 2 MB.
  localparam int unsigned SramAddrW = 21;

  // Width of the per-phase down-counter; phases are at most 256 cycles long.
  localparam int unsigned PhaseCntW = 8;

  // Bus-cycle phases.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StStrobe = 2'd2,
    StHold   = 2'd3
  } icd_state_e;

  // Counter preload for a phase of 'cycles' clocks; zero-length phases are
  // skipped by the FSM and never load.
  function automatic logic [PhaseCntW-1:0] phase_load(int unsigned cycles);
    return (cycles == 0) ? '0 : PhaseCntW'(cycles - 1);
  endfunction

endpackage

// File: rtl/icd_mem_master_if.sv
// Request/response handshake plus SRAM bus pins of the ICD memory initiator.
interface icd_mem_master_if
  import icd_mem_master_pkg::*;
#(
  parameter int unsigned ADDR_W = SramAddrW
);

  // Handshake with the ICD command decoder.
  logic              bus_grant;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              rsp_valid;
  logic [7:0]        rsp_rdata;
  logic              busy;

  // Memory-bus pins towards the top-level muxes.
  logic [ADDR_W-13:0] mah_o;
  logic [11:0]        mal_o;
  logic               mal_oe;
  logic [7:0]         md_o;
  logic               md_oe;
  logic [7:0]         md_i;
  logic               m1cs_n;
  logic               mrd_n;
  logic               mwr_n;

  // View of the initiator block itself.
  modport master (
    input  bus_grant, req_valid, req_write, req_addr, req_wdata, md_i,
    output req_ready, rsp_valid, rsp_rdata, busy,
    output mah_o, mal_o, mal_oe, md_o, md_oe, m1cs_n, mrd_n, mwr_n
  );

  // View of the decoder / memory side that talks to the initiator.
  modport slave (
    output bus_grant, req_valid, req_write, req_addr, req_wdata, md_i,
    input  req_ready, rsp_valid, rsp_rdata, busy,
    input  mah_o, mal_o, mal_oe, md_o, md_oe, m1cs_n, mrd_n, mwr_n
  );

endinterface

// File: rtl/icd_mem_master_phase_counter.sv
// Down-counter shared by the SETUP, STROBE and HOLD phases.
// Loaded with (phase length - 1) on phase entry; zero_o marks the last cycle.
module icd_mem_master_phase_counter
  import icd_mem_master_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [PhaseCntW-1:0] load_val_i,
  output logic                 zero_o
);

  logic [PhaseCntW-1:0] cnt_q;

  // Load on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/icd_mem_master.sv
// ICD memory-bus initiator: single-byte SRAM read/write cycles with
// programmable setup, strobe and hold phases while the CPU is halted.
module icd_mem_master
  import icd_mem_master_pkg::*;
#(
  parameter int unsigned ADDR_W     = SramAddrW,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 3,
  parameter int unsigned HOLD_CYC   = 1
) (
  input logic              clk6x,
  input logic              reset,
  icd_mem_master_if.master bus
);

  icd_state_e state_q, state_d;

  logic                 accept;
  logic                 phase_done;
  logic                 cnt_load;
  logic [PhaseCntW-1:0] cnt_val;

  // Transaction latches; these also feed the address and data pins directly.
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;

  // Registered pin and status outputs.
  logic rsp_valid_q, rsp_valid_d;
  logic busy_q, busy_d;
  logic m1cs_n_q, m1cs_n_d;
  logic mrd_n_q, mrd_n_d;
  logic mwr_n_q, mwr_n_d;
  logic mal_oe_q, mal_oe_d;
  logic md_oe_q, md_oe_d;

  // bus_grant only matters in IDLE: a cycle already under way always completes.
  assign bus.req_ready = (state_q == StIdle) & bus.bus_grant & ~reset;
  assign accept        = bus.req_valid & bus.req_ready;

  icd_mem_master_phase_counter u_phase_counter (
    .clk_i      (clk6x),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .zero_o     (phase_done)
  );

  // State register.
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; zero-length setup/hold phases are skipped entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = (SETUP_CYC != 0) ? StSetup : StStrobe;
        end
      end
      StSetup: begin
        if (phase_done) begin
          state_d = StStrobe;
        end
      end
      StStrobe: begin
        if (phase_done) begin
          state_d = (HOLD_CYC != 0) ? StHold : StIdle;
        end
      end
      StHold: begin
        if (phase_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Reload the phase counter whenever a new phase starts.
    cnt_load = (state_d != state_q);
    case (state_d)
      StSetup:  cnt_val = phase_load(SETUP_CYC);
      StStrobe: cnt_val = phase_load(STROBE_CYC);
      StHold:   cnt_val = phase_load(HOLD_CYC);
      default:  cnt_val = '0;
    endcase
  end

  // Output logic: next values of the registered pins, derived from the next state
  // so every pin changes on the same edge as the state it belongs to.
  always_comb begin
    wr_d    = accept ? bus.req_write : wr_q;
    addr_d  = accept ? bus.req_addr  : addr_q;
    wdata_d = accept ? bus.req_wdata : wdata_q;

    busy_d   = (state_d != StIdle);
    m1cs_n_d = (state_d == StIdle);
    mal_oe_d = (state_d != StIdle);
    md_oe_d  = (state_d != StIdle) & wr_d;
    mrd_n_d  = ~((state_d == StStrobe) & ~wr_d);
    mwr_n_d  = ~((state_d == StStrobe) & wr_d);

    // Completion pulse on the edge that returns to IDLE.
    rsp_valid_d = (state_q != StIdle) & (state_d == StIdle);

    // Read data is captured on the edge where mrd_n rises.
    rdata_d = rdata_q;
    if ((state_q == StStrobe) && (state_d != StStrobe) && !wr_q) begin
      rdata_d = bus.md_i;
    end
  end

  // Output and transaction registers; reset releases every strobe and enable at once.
  always_ff @(posedge clk6x or posedge reset) begin
    if (reset) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      m1cs_n_q    <= 1'b1;
      mrd_n_q     <= 1'b1;
      mwr_n_q     <= 1'b1;
      mal_oe_q    <= 1'b0;
      md_oe_q     <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
      m1cs_n_q    <= m1cs_n_d;
      mrd_n_q     <= mrd_n_d;
      mwr_n_q     <= mwr_n_d;
      mal_oe_q    <= mal_oe_d;
      md_oe_q     <= md_oe_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mah_o     = addr_q[ADDR_W-1:12];
  assign bus.mal_o     = addr_q[11:0];
  assign bus.mal_oe    = mal_oe_q;
  assign bus.md_o      = wdata_q;
  assign bus.md_oe     = md_oe_q;
  assign bus.m1cs_n    = m1cs_n_q;
  assign bus.mrd_n     = mrd_n_q;
  assign bus.mwr_n     = mwr_n_q;

endmodule

// File: tb/tb_icd_mem_master.sv
// Scoreboard bench: default-timing instance (1/3/1) plus a fast instance (0/1/0),
// each with a small SRAM model driving md_i.
module tb_icd_mem_master;

  localparam int Lat1 = 1 + 3 + 1 + 1;
  localparam int Lat2 = 0 + 1 + 0 + 1;

  typedef struct {
    logic        rd;
    logic [7:0]  data;
    logic [20:0] addr;
    int          due;
  } exp_t;

  logic clk6x = 1'b0;
  logic rst   = 1'b1;
  int   cyc   = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  logic [7:0] mem1 [int unsigned];
  logic [7:0] mem2 [int unsigned];
  logic [7:0] md1 = 8'hEE;
  logic [7:0] md2 = 8'hEE;

  always #10400ps clk6x = ~clk6x;
  always @(posedge clk6x) cyc <= cyc + 1;

  icd_mem_master_if b1 ();
  icd_mem_master_if b2 ();

  assign b1.md_i = md1;
  assign b2.md_i = md2;

  icd_mem_master #(
    .ADDR_W(21), .SETUP_CYC(1), .STROBE_CYC(3), .HOLD_CYC(1)
  ) u_dut (
    .clk6x (clk6x),
    .reset (rst),
    .bus   (b1.master)
  );

  icd_mem_master #(
    .ADDR_W(21), .SETUP_CYC(0), .STROBE_CYC(1), .HOLD_CYC(0)
  ) u_dut_fast (
    .clk6x (clk6x),
    .reset (rst),
    .bus   (b2.master)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // SRAM read with 20 ns access time on the default instance.
  always begin
    @(negedge b1.mrd_n);
    #20ns;
    if (!b1.mrd_n && !b1.m1cs_n) md1 = mem1[32'({b1.mah_o, b1.mal_o})];
    @(posedge b1.mrd_n);
    md1 = 8'hEE;
  end

  // Faster part on the single-cycle-strobe instance.
  always begin
    @(negedge b2.mrd_n);
    #8ns;
    if (!b2.mrd_n && !b2.m1cs_n) md2 = mem2[32'({b2.mah_o, b2.mal_o})];
    @(posedge b2.mrd_n);
    md2 = 8'hEE;
  end

  // Monitor for the default instance: responses, pin timing, SRAM write latch.
  int          cs_run1, st_run1;
  logic        mwr_prev1;
  logic [7:0]  wr_data1;
  logic [20:0] wr_addr1;
  always @(negedge clk6x) begin
    if (rst) begin
      cs_run1 = 0; st_run1 = 0; mwr_prev1 = 1'b1;
    end else begin
      if (b1.rsp_valid) begin
        if (q1.size() == 0) check("rsp1_unexpected", 32'(b1.rsp_valid), 32'd0);
        else begin
          e1 = q1.pop_front();
          check("rsp1_latency", 32'(cyc), 32'(e1.due));
          if (e1.rd) check("rsp1_rdata", 32'(b1.rsp_rdata), 32'(e1.data));
        end
      end
      check("busy1", 32'(b1.busy), 32'(!b1.m1cs_n));
      if (!b1.m1cs_n) begin
        cs_run1++;
        check("mal_oe_in_cycle", 32'(b1.mal_oe), 32'd1);
        if (q1.size() != 0) begin
          check("addr_pins", 32'({b1.mah_o, b1.mal_o}), 32'(q1[0].addr));
          check("md_oe_dir", 32'(b1.md_oe), 32'(!q1[0].rd));
        end
      end else begin
        if (cs_run1 != 0) check("cs_low_cycles", 32'(cs_run1), 32'd5);
        cs_run1 = 0;
        check("oe_in_idle", 32'({b1.mal_oe, b1.md_oe}), 32'd0);
      end
      if (!b1.mrd_n || !b1.mwr_n) st_run1++;
      else begin
        if (st_run1 != 0) check("strobe_low_cycles", 32'(st_run1), 32'd3);
        st_run1 = 0;
      end
      if (!b1.mwr_n) begin
        wr_data1 = b1.md_o;
        wr_addr1 = {b1.mah_o, b1.mal_o};
      end
      if (!mwr_prev1 && b1.mwr_n) begin
        check("md_oe_at_mwr_rise", 32'(b1.md_oe), 32'd1);
        check("md_stable_at_mwr_rise", 32'(b1.md_o), 32'(wr_data1));
        mem1[32'(wr_addr1)] = wr_data1;
      end
      mwr_prev1 = b1.mwr_n;
    end
  end

  // Monitor for the fast instance.
  logic        mwr_prev2;
  logic [7:0]  wr_data2;
  logic [20:0] wr_addr2;
  always @(negedge clk6x) begin
    if (rst) begin
      mwr_prev2 = 1'b1;
    end else begin
      if (b2.rsp_valid) begin
        if (q2.size() == 0) check("rsp2_unexpected", 32'(b2.rsp_valid), 32'd0);
        else begin
          e2 = q2.pop_front();
          check("rsp2_latency", 32'(cyc), 32'(e2.due));
          if (e2.rd) check("rsp2_rdata", 32'(b2.rsp_rdata), 32'(e2.data));
        end
      end
      if (!b2.mwr_n) begin
        wr_data2 = b2.md_o;
        wr_addr2 = {b2.mah_o, b2.mal_o};
      end
      if (!mwr_prev2 && b2.mwr_n) mem2[32'(wr_addr2)] = wr_data2;
      mwr_prev2 = b2.mwr_n;
    end
  end

  // Present a request and wait (bounded) for acceptance; for reads 'data' is the
  // expected read value.
  task automatic issue1(input logic wr, input logic [20:0] addr, input logic [7:0] data,
                        output int waits);
    exp_t e;
    @(negedge clk6x);
    b1.req_valid = 1'b1; b1.req_write = wr; b1.req_addr = addr; b1.req_wdata = data;
    #1ns;
    waits = 0;
    while (!b1.req_ready && waits < 40) begin
      @(negedge clk6x); #1ns; waits++;
    end
    check("accept1", 32'(b1.req_ready), 32'd1);
    if (b1.req_ready) begin
      e.rd = !wr; e.data = data; e.addr = addr; e.due = cyc + Lat1;
      q1.push_back(e);
      @(posedge clk6x); #1ns;
    end
    b1.req_valid = 1'b0;
  endtask

  task automatic issue2(input logic wr, input logic [20:0] addr, input logic [7:0] data);
    exp_t e;
    int   waits;
    @(negedge clk6x);
    b2.req_valid = 1'b1; b2.req_write = wr; b2.req_addr = addr; b2.req_wdata = data;
    #1ns;
    waits = 0;
    while (!b2.req_ready && waits < 40) begin
      @(negedge clk6x); #1ns; waits++;
    end
    check("accept2", 32'(b2.req_ready), 32'd1);
    if (b2.req_ready) begin
      e.rd = !wr; e.data = data; e.addr = addr; e.due = cyc + Lat2;
      q2.push_back(e);
      @(posedge clk6x); #1ns;
    end
    b2.req_valid = 1'b0;
  endtask

  task automatic drain1();
    int n = 0;
    while ((q1.size() != 0 || b1.busy) && n < 60) begin
      @(negedge clk6x); n++;
    end
    @(negedge clk6x);
    check("drain1", 32'(q1.size()), 32'd0);
  endtask

  task automatic drain2();
    int n = 0;
    while ((q2.size() != 0 || b2.busy) && n < 60) begin
      @(negedge clk6x); n++;
    end
    @(negedge clk6x);
    check("drain2", 32'(q2.size()), 32'd0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    b1.bus_grant = 1'b1; b1.req_valid = 1'b0; b1.req_write = 1'b0;
    b1.req_addr = '0; b1.req_wdata = '0;
    b2.bus_grant = 1'b1; b2.req_valid = 1'b0; b2.req_write = 1'b0;
    b2.req_addr = '0; b2.req_wdata = '0;
    mem1[32'h1ABCD] = 8'hA5;
    mem2[32'h00100] = 8'h3C;
    mem2[32'h1FFFF] = 8'hC3;

    // Reset values while reset is held.
    @(negedge clk6x);
    check("rst_strobes", 32'({b1.m1cs_n, b1.mrd_n, b1.mwr_n}), 32'h7);
    check("rst_oe", 32'({b1.mal_oe, b1.md_oe}), 32'd0);
    check("rst_ctrl", 32'({b1.req_ready, b1.rsp_valid, b1.busy}), 32'd0);
    check("rst_addr", 32'({b1.mah_o, b1.mal_o}), 32'd0);
    check("rst_data", 32'({b1.rsp_rdata, b1.md_o}), 32'd0);
    repeat (2) @(negedge clk6x);
    rst = 1'b0;

    // Single write, then back-to-back writes and read-back.
    issue1(1'b1, 21'h00010, 8'h12, w);
    drain1();
    check("sram_0x10", 32'(mem1[32'h10]), 32'h12);
    issue1(1'b1, 21'h00011, 8'h34, w);
    issue1(1'b1, 21'h00012, 8'h56, w);
    check("b2b_accept_gap", 32'(w), 32'd5);
    issue1(1'b1, 21'h00013, 8'h78, w);
    issue1(1'b0, 21'h00010, 8'h12, w);
    issue1(1'b0, 21'h00011, 8'h34, w);
    issue1(1'b0, 21'h00012, 8'h56, w);
    issue1(1'b0, 21'h00013, 8'h78, w);
    drain1();

    // Address split across MAH/MAL.
    issue1(1'b0, 21'h1ABCD, 8'hA5, w);
    drain1();

    // No grant: nothing accepted, bus stays quiet.
    @(negedge clk6x);
    b1.bus_grant = 1'b0; b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 21'h00011;
    repeat (4) begin
      #1ns;
      check("ready_no_grant", 32'(b1.req_ready), 32'd0);
      check("strobes_no_grant", 32'({b1.m1cs_n, b1.mrd_n, b1.mwr_n}), 32'h7);
      @(negedge clk6x);
    end
    b1.req_valid = 1'b0; b1.bus_grant = 1'b1;
    issue1(1'b0, 21'h00011, 8'h34, w);
    check("accept_after_grant", 32'(w), 32'd0);

    // Grant drops during STROBE: cycle completes, next request held off.
    drain1();
    issue1(1'b0, 21'h00012, 8'h56, w);
    repeat (2) @(negedge clk6x);
    check("in_strobe_at_drop", 32'(b1.mrd_n), 32'd0);
    b1.bus_grant = 1'b0; b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_addr = 21'h00013;
    repeat (8) begin
      #1ns;
      check("ready_after_drop", 32'(b1.req_ready), 32'd0);
      @(negedge clk6x);
    end
    check("rsp_after_drop", 32'(q1.size()), 32'd0);
    b1.req_valid = 1'b0; b1.bus_grant = 1'b1;
    issue1(1'b0, 21'h00013, 8'h78, w);
    drain1();

    // Reset in the middle of a write strobe.
    issue1(1'b1, 21'h00020, 8'h99, w);
    w = 0;
    while (b1.mwr_n && w < 10) begin
      @(negedge clk6x); w++;
    end
    check("reached_write_strobe", 32'(b1.mwr_n), 32'd0);
    #2ns;
    rst = 1'b1;
    #1ns;
    check("rst_async_release",
          32'({b1.mwr_n, b1.m1cs_n, b1.md_oe, b1.mal_oe, b1.busy}), 32'b11000);
    q1.delete();
    repeat (2) @(negedge clk6x);
    rst = 1'b0;
    #1ns;
    check("ready_after_reset", 32'(b1.req_ready), 32'd1);
    check("no_write_on_reset", 32'(mem1.exists(32'h20)), 32'd0);
    repeat (8) @(negedge clk6x);
    issue1(1'b0, 21'h00013, 8'h78, w);
    drain1();

    // Minimal timing: no setup/hold, one-cycle strobe.
    issue2(1'b0, 21'h00100, 8'h3C);
    issue2(1'b0, 21'h1FFFF, 8'hC3);
    issue2(1'b1, 21'h00200, 8'h5A);
    issue2(1'b0, 21'h00200, 8'h5A);
    drain2();
    check("sram2_0x200", 32'(mem2[32'h200]), 32'h5A);

    repeat (3) @(negedge clk6x);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
